// File: rtl/uart_rx_if.sv
// Handshake and status bundle between the 8N1 UART receiver and its consumer.
interface uart_rx_if;
  logic       i_uart_rx;
  logic       i_ready;
  logic       i_clear;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  modport slave (
    input  i_uart_rx, i_ready, i_clear,
    output o_data, o_valid, o_frame_err, o_overrun, o_busy
  );

  modport master (
    output i_uart_rx, i_ready, i_clear,
    input  o_data, o_valid, o_frame_err, o_overrun, o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, a one-byte holding register with a
// valid/ready handshake, and sticky framing/overrun flags.
module uart_rx #(
  parameter int clk_freq_hz = 10000000,
  parameter int baud_rate   = 1000000
) (
  input logic     clk,
  input logic     resetn,
  uart_rx_if.slave bus
);

  localparam int DIV  = clk_freq_hz / baud_rate;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          sync1;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          deliver;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_q;
  logic          overrun_q;
  logic          consume;

  // rx_prev lets IDLE demand a genuine 1->0 transition, so a line stuck low
  // after a framing error cannot restart reception.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= bus.i_uart_rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      deliver <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      deliver <= 1'b0;
      if (bus.i_clear) frame_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            // Set wins over a simultaneous clear because it is assigned last.
            if (rx_s) deliver <= 1'b1;
            else      frame_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign consume = valid_q && bus.i_ready;

  // A byte arriving while the holding register is full and not being
  // consumed is dropped; a same-cycle consume frees the slot for it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.i_clear) overrun_q <= 1'b0;
      if (deliver) begin
        if (!valid_q || consume) begin
          data_q  <= shift;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (consume) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter clk_freq_hz, default 10000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 1000000, serial bit rate; DIV = clk_freq_hz/baud_rate (10 by default), HALF = DIV/2; DIV >= 4 required.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port i_ready  input  1  consumer accepts o_data when high with o_valid.
REQ-007 SHALL have port i_clear  input  1  clears sticky error flags.
REQ-008 SHALL have port o_data  output  8  received byte.
REQ-009 SHALL have port o_valid  output  1  o_data holds an unconsumed byte.
REQ-010 SHALL have port o_frame_err  output  1  sticky, stop bit sampled low.
REQ-011 SHALL have port o_overrun  output  1  sticky, byte lost because holding register full.
REQ-012 SHALL have port o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 SHALL pass i_uart_rx through a 2-flop synchronizer (reset value 1); output rx_s drives all logic.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP with a bit-period counter of width clog2(DIV) and 3-bit bit index.
REQ-015 IDLE -> START only on a falling edge of rx_s (previous 1, current 0); counter cleared.
REQ-016 START: at counter == HALF-1, rx_s==0 -> DATA (counter and bit index cleared), rx_s==1 -> IDLE (glitch rejected, nothing reported).
REQ-017 DATA: sample rx_s at counter == DIV-1, shift into bit[index] LSB first, counter wraps to 0; after index 7 -> STOP.
REQ-018 STOP: sample at counter == DIV-1; rx_s==1 -> byte delivered per REQ-020, rx_s==0 -> o_frame_err set, byte discarded; both -> IDLE.
REQ-019 After framing error, new reception SHALL require rx_s to return high first (falling-edge rule of REQ-015).
REQ-020 Delivery: one cycle after stop sample, o_data loaded and o_valid set, unless holding register still full.
REQ-021 Handshake: o_valid && i_ready on a clock edge consumes the byte; o_valid clears next cycle; o_data stable while o_valid high and not consumed.
REQ-022 Delivery with o_valid high and no consume in the same cycle: new byte discarded, o_data/o_valid unchanged, o_overrun set.
REQ-023 Delivery coinciding with consume: new byte loaded, o_valid stays 1, no overrun.
REQ-024 i_clear clears o_frame_err and o_overrun next cycle; a simultaneous set event wins over clear.
REQ-025 Latency: o_valid rises 98 cycles (defaults; 2+HALF+9*DIV+1 in general) after the first edge sampling i_uart_rx low; bench tolerance +/-1.
REQ-026 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-027 resetn low SHALL asynchronously force: FSM IDLE, counters 0, synchronizer 1, o_data 0x00, o_valid 0, o_frame_err 0, o_overrun 0, o_busy 0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; after resetn rises, the next falling edge starts a fresh frame.

Verification
REQ-029 Send 0xA5 at 10 clk/bit, i_ready=1 -> o_data=0xA5, o_valid one-cycle pulse at 98+/-1 cycles, errors 0.
REQ-030 Drive i_uart_rx low 3 cycles then high -> o_busy pulses, returns IDLE, o_valid stays 0.
REQ-031 Send 0x3C with stop bit 0 -> o_frame_err=1, o_valid 0; then line high, send 0x55 -> o_data=0x55 delivered, o_frame_err still 1 until i_clear.
REQ-032 i_ready=0, send 0x11 then 0x22 -> o_data=0x11, o_overrun=1; raise i_ready -> 0x11 consumed; i_clear -> o_overrun=0.
REQ-033 Assert resetn low during DATA bit 4 of 0xFF -> all outputs reset values; release, send 0x81 -> o_data=0x81 only.
REQ-034 Send 0x00 then 0xFF with no idle gap, i_ready=1 -> two deliveries, 0x00 then 0xFF, no errors.
